// File: rtl/ultrasonic_ping_scheduler.sv
// Round-robin ping scheduler: fires one ultrasonic sensor at a time, times its
// synchronized echo pulse in clk cycles and reports one result per ping.
module ultrasonic_ping_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int ID_W           = 2,
    parameter int CNT_W          = 24,
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int GAP_CYCLES     = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   busy,
    output logic                   result_valid,
    output logic [ID_W-1:0]        result_id,
    output logic [CNT_W-1:0]       echo_cycles,
    output logic                   result_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_SENSORS - 1);

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d;
    logic [ID_W-1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       ecnt_q, ecnt_d;
    logic [NUM_SENSORS-1:0] sync1_q, sync2_q, sync3_q;
    logic                   res_valid_q, res_valid_d;
    logic [ID_W-1:0]        res_id_q, res_id_d;
    logic [CNT_W-1:0]       res_cyc_q, res_cyc_d;
    logic                   res_tmo_q, res_tmo_d;

    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        idx;
    logic                   sel, sel_prev, rise, fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lowest offset from the round-robin pointer wins, so scan offsets high to low.
    always_comb begin
        pick_id = rr_q;
        idx     = '0;
        for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_SENSORS);
            if (sensor_mask[idx]) pick_id = idx;
        end
    end

    assign sel      = sync2_q[cur_id_q];
    assign sel_prev = sync3_q[cur_id_q];
    assign rise     = sel & ~sel_prev;
    assign fall     = ~sel & sel_prev;

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        ecnt_d      = ecnt_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_cyc_d   = res_cyc_q;
        res_tmo_d   = res_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (|sensor_mask)) begin
                    cur_id_d = pick_id;
                    cnt_d    = '0;
                    state_d  = S_TRIG;
                end
            end
            S_TRIG: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE, S_MEASURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A fall on the last allowed cycle still counts as a valid echo.
                if (state_q == S_MEASURE && fall) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    res_id_d    = cur_id_q;
                    res_cyc_d   = ecnt_q;
                    res_tmo_d   = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    res_valid_d = 1'b1;
                    res_id_d    = cur_id_q;
                    res_cyc_d   = '1;
                    res_tmo_d   = 1'b1;
                end else if (state_q == S_WAIT_RISE && rise) begin
                    state_d = S_MEASURE;
                    ecnt_d  = CNT_W'(1);
                end else if (state_q == S_MEASURE && sel) begin
                    ecnt_d = sat_inc(ecnt_q);
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    rr_d    = (cur_id_q == LAST_ID) ? '0 : cur_id_q + ID_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_id_q    <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            ecnt_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_cyc_q   <= '0;
            res_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            ecnt_q      <= ecnt_d;
            sync1_q     <= echo;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_cyc_q   <= res_cyc_d;
            res_tmo_q   <= res_tmo_d;
        end
    end

    always_comb begin
        trigger = '0;
        if (state_q == S_TRIG) trigger[cur_id_q] = 1'b1;
    end

    assign busy           = (state_q != S_IDLE);
    assign result_valid   = res_valid_q;
    assign result_id      = res_id_q;
    assign echo_cycles    = res_cyc_q;
    assign result_timeout = res_tmo_q;

endmodule
